// File: rtl/mem_responder.sv
// Multi-channel byte-wide memory responder: each channel runs IDLE/BUSY/RESPOND/RELEASE
// with a fixed LATENCY. Optional MEM_RESPONDER_WRITE_GUARD_EN blocks commits to addresses >= 'hF0.
module mem_responder #(
    parameter int CHANNELS  = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           mem_read_valid,
    input  logic [CHANNELS*ADDR_BITS-1:0] mem_read_address,
    output logic [CHANNELS-1:0]           mem_read_ready,
    output logic [CHANNELS*DATA_BITS-1:0] mem_read_data,
    input  logic [CHANNELS-1:0]           mem_write_valid,
    input  logic [CHANNELS*ADDR_BITS-1:0] mem_write_address,
    input  logic [CHANNELS*DATA_BITS-1:0] mem_write_data,
    output logic [CHANNELS-1:0]           mem_write_ready,
`ifdef MEM_RESPONDER_WRITE_GUARD_EN
    output logic                          write_violation,
`endif
    output logic [2*CHANNELS-1:0]         fsm_state
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    // Handshake: a request is held valid until its ready pulse; ready is a one-cycle
    // pulse in RESPOND; the channel only re-arms once the served valid has dropped.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2,
        RELEASE = 2'd3
    } state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [CHANNELS-1:0]  commit;
    logic [CHANNELS-1:0]  guarded;
    logic [ADDR_BITS-1:0] c_addr [CHANNELS];
    logic [DATA_BITS-1:0] c_data [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t               state;
        logic [3:0]           cnt;
        logic [ADDR_BITS-1:0] addr_q;
        logic [DATA_BITS-1:0] wdata_q;
        logic                 is_write;
        logic                 rd_rdy;
        logic                 wr_rdy;
        logic [DATA_BITS-1:0] rdata;
        logic                 finish;

        assign finish    = (state == BUSY) && (cnt == 4'd0);
        assign commit[g] = finish && is_write;
        assign c_addr[g] = addr_q;
        assign c_data[g] = wdata_q;

        assign mem_read_ready[g]                    = rd_rdy;
        assign mem_write_ready[g]                   = wr_rdy;
        assign mem_read_data[g*DATA_BITS +: DATA_BITS] = rdata;
        assign fsm_state[2*g +: 2]                  = state;

`ifdef MEM_RESPONDER_WRITE_GUARD_EN
        assign guarded[g] = (addr_q >= ADDR_BITS'('hF0));
`else
        assign guarded[g] = 1'b0;
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state    <= IDLE;
                cnt      <= 4'd0;
                addr_q   <= '0;
                wdata_q  <= '0;
                is_write <= 1'b0;
                rd_rdy   <= 1'b0;
                wr_rdy   <= 1'b0;
                rdata    <= '0;
            end else begin
                rd_rdy <= 1'b0;
                wr_rdy <= 1'b0;
                case (state)
                    IDLE: begin
                        // Read wins when both are requested; the write waits for a later acceptance.
                        if (mem_read_valid[g]) begin
                            addr_q   <= mem_read_address[g*ADDR_BITS +: ADDR_BITS];
                            cnt      <= 4'(LATENCY - 1);
                            is_write <= 1'b0;
                            state    <= BUSY;
                        end else if (mem_write_valid[g]) begin
                            addr_q   <= mem_write_address[g*ADDR_BITS +: ADDR_BITS];
                            wdata_q  <= mem_write_data[g*DATA_BITS +: DATA_BITS];
                            cnt      <= 4'(LATENCY - 1);
                            is_write <= 1'b1;
                            state    <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (cnt == 4'd0) begin
                            state <= RESPOND;
                            if (is_write) begin
                                wr_rdy <= 1'b1;
                            end else begin
                                rd_rdy <= 1'b1;
                                rdata  <= mem[addr_q];
                            end
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    RESPOND: state <= RELEASE;
                    RELEASE: begin
                        if (!(is_write ? mem_write_valid[g] : mem_read_valid[g])) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Descending scan so the lowest channel's write is the one that sticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
        end else begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (commit[i] && !guarded[i]) mem[c_addr[i]] <= c_data[i];
            end
        end
    end

`ifdef MEM_RESPONDER_WRITE_GUARD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) write_violation <= 1'b0;
        else if (|(commit & guarded)) write_violation <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table of single-channel transactions
// followed by hand-written multi-channel, hold, early-drop and reset sequences.
module tb_mem_responder;

    localparam int CH  = 4;
    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int LAT = 2;

    logic            clk;
    logic            reset;
    logic [CH-1:0]   rv;
    logic [CH*AB-1:0] ra;
    logic [CH-1:0]   rd_ready;
    logic [CH*DB-1:0] rd_data;
    logic [CH-1:0]   wv;
    logic [CH*AB-1:0] wa;
    logic [CH*DB-1:0] wd;
    logic [CH-1:0]   wr_ready;
    logic [2*CH-1:0] fsm_state;
`ifdef MEM_RESPONDER_WRITE_GUARD_EN
    logic            write_violation;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    mem_responder #(.CHANNELS(CH), .ADDR_BITS(AB), .DATA_BITS(DB), .LATENCY(LAT)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_valid    (rv),
        .mem_read_address  (ra),
        .mem_read_ready    (rd_ready),
        .mem_read_data     (rd_data),
        .mem_write_valid   (wv),
        .mem_write_address (wa),
        .mem_write_data    (wd),
        .mem_write_ready   (wr_ready),
`ifdef MEM_RESPONDER_WRITE_GUARD_EN
        .write_violation   (write_violation),
`endif
        .fsm_state         (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        int         ch;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t       vecs[12];
    logic [7:0] last_rd[CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete single-channel transaction; valid is dropped in the ready cycle.
    task automatic run_txn(input bit wr, input int ch, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] exp_rd);
        int n;
        bit seen;
        @(negedge clk);
        if (wr) begin
            wv[ch] = 1'b1; wa[ch*AB +: AB] = a; wd[ch*DB +: DB] = d;
        end else begin
            rv[ch] = 1'b1; ra[ch*AB +: AB] = a;
        end
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = wr ? wr_ready[ch] : rd_ready[ch];
        end
        check("latency", n - 1, LAT);
        check("ready_vec", {rd_ready, wr_ready},
              wr ? {4'b0, 4'(1 << ch)} : {4'(1 << ch), 4'b0});
        if (!wr) check("rdata", rd_data[ch*DB +: DB], exp_rd);
        rv[ch] = 1'b0; wv[ch] = 1'b0;
        @(negedge clk);
        check("pulse_width", {rd_ready, wr_ready}, 8'h00);
        @(negedge clk);
        check("back_idle", fsm_state[2*ch +: 2], 2'd0);
    endtask

    task automatic wait_any_ready(output int n);
        n = 0;
        while ((rd_ready | wr_ready) == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int pulses;

        vecs[0]  = '{1'b1, 0, 8'h10, 8'hA5, 8'h00};
        vecs[1]  = '{1'b0, 1, 8'h10, 8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 0, 8'h00, 8'h11, 8'h00};
        vecs[3]  = '{1'b1, 1, 8'h01, 8'h22, 8'h00};
        vecs[4]  = '{1'b1, 2, 8'h02, 8'h33, 8'h00};
        vecs[5]  = '{1'b1, 3, 8'h03, 8'h44, 8'h00};
        vecs[6]  = '{1'b0, 2, 8'h03, 8'h00, 8'h44};
        vecs[7]  = '{1'b1, 2, 8'h10, 8'h5C, 8'h00};
        vecs[8]  = '{1'b0, 3, 8'h10, 8'h00, 8'h5C};
        vecs[9]  = '{1'b0, 0, 8'hFF, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 1, 8'hEF, 8'hC3, 8'h00};
        vecs[11] = '{1'b0, 0, 8'hEF, 8'h00, 8'hC3};
        for (int c = 0; c < CH; c++) last_rd[c] = 8'h00;

        reset = 1'b0; rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
        repeat (2) @(negedge clk);
        check("rst_state", fsm_state, '0);
        check("rst_ready", {rd_ready, wr_ready}, 8'h00);
        check("rst_rdata", rd_data, 32'h0);
`ifdef MEM_RESPONDER_WRITE_GUARD_EN
        check("rst_violation", write_violation, 1'b0);
`endif
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].wr, vecs[i].ch, vecs[i].addr, vecs[i].data, vecs[i].exp_rd);
            if (vecs[i].wr) check("rdata_hold", rd_data[vecs[i].ch*DB +: DB], last_rd[vecs[i].ch]);
            else last_rd[vecs[i].ch] = vecs[i].exp_rd;
        end

        // All four channels read in the same cycle.
        @(negedge clk);
        rv = 4'hF; ra = {8'h03, 8'h02, 8'h01, 8'h00};
        wait_any_ready(n);
        check("par_latency", n - 1, LAT);
        check("par_ready", rd_ready, 4'hF);
        check("par_rdata", rd_data, 32'h44332211);
        rv = '0;
        repeat (2) @(negedge clk);

        // Two channels commit to one address on the same edge.
        wv = 4'b1010; wa = {8'h20, 8'h00, 8'h20, 8'h00}; wd = {8'h02, 8'h00, 8'h01, 8'h00};
        wait_any_ready(n);
        check("dual_wr_ready", wr_ready, 4'b1010);
        wv = '0;
        repeat (2) @(negedge clk);
        run_txn(1'b0, 0, 8'h20, 8'h00, 8'h01);

        // Read sample and write commit to one address on the same edge.
        run_txn(1'b1, 0, 8'h40, 8'h33, 8'h00);
        @(negedge clk);
        wv[0] = 1'b1; wa[7:0] = 8'h40; wd[7:0] = 8'h5A;
        rv[1] = 1'b1; ra[15:8] = 8'h40;
        wait_any_ready(n);
        check("rw_ready", {rd_ready, wr_ready}, 8'h21);
        check("rw_old_data", rd_data[15:8], 8'h33);
        wv = '0; rv = '0;
        repeat (2) @(negedge clk);
        run_txn(1'b0, 2, 8'h40, 8'h00, 8'h5A);

        // Valid held after the ready pulse: no second ready until it drops.
        @(negedge clk);
        rv[2] = 1'b1; ra[23:16] = 8'h10;
        wait_any_ready(n);
        check("hold_first", rd_ready, 4'b0100);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_no_repeat", rd_ready, 4'b0000);
        end
        check("hold_release", fsm_state[5:4], 2'd3);
        rv[2] = 1'b0;
        @(negedge clk);
        check("hold_idle", fsm_state[5:4], 2'd0);
        run_txn(1'b0, 2, 8'h10, 8'h00, 8'h5C);

        // Valid dropped during BUSY still completes with one pulse.
        @(negedge clk);
        wv[1] = 1'b1; wa[15:8] = 8'h50; wd[15:8] = 8'h66;
        @(negedge clk);
        wv[1] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (wr_ready[1]) pulses++;
        end
        check("early_drop_pulses", pulses, 1);
        run_txn(1'b0, 0, 8'h50, 8'h00, 8'h66);

        // Read and write requested together: read first, then the write.
        @(negedge clk);
        rv[3] = 1'b1; ra[31:24] = 8'h60; wv[3] = 1'b1; wa[31:24] = 8'h60; wd[31:24] = 8'h99;
        wait_any_ready(n);
        check("prio_read_first", {rd_ready[3], wr_ready[3]}, 2'b10);
        check("prio_rdata", rd_data[31:24], 8'h00);
        rv[3] = 1'b0;
        n = 0;
        while (!wr_ready[3] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("prio_write_later", wr_ready[3], 1'b1);
        wv[3] = 1'b0;
        repeat (2) @(negedge clk);
        run_txn(1'b0, 3, 8'h60, 8'h00, 8'h99);

        // Reset during a write's BUSY phase.
        @(negedge clk);
        wv[0] = 1'b1; wa[7:0] = 8'h30; wd[7:0] = 8'hFF;
        @(negedge clk);
        check("pre_rst_busy", fsm_state[1:0], 2'd1);
        reset = 1'b0; wv = '0;
        #1;
        check("mid_rst_state", fsm_state, '0);
        check("mid_rst_rdata", rd_data, 32'h0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (wr_ready != '0 || rd_ready != '0) pulses++;
        end
        check("mid_rst_no_pulse", pulses, 0);
        reset = 1'b1;
        run_txn(1'b0, 1, 8'h30, 8'h00, 8'h00);
        run_txn(1'b0, 2, 8'h10, 8'h00, 8'h00);

`ifdef MEM_RESPONDER_WRITE_GUARD_EN
        check("guard_clear", write_violation, 1'b0);
        run_txn(1'b1, 0, 8'hF4, 8'h77, 8'h00);
        check("guard_violation", write_violation, 1'b1);
        run_txn(1'b0, 1, 8'hF4, 8'h00, 8'h00);
        check("guard_sticky", write_violation, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: CHANNELS, 4, number of independent request channels.
REQ-002 Parameter: ADDR_BITS, 8, address width per channel; storage depth is 2^ADDR_BITS bytes.
REQ-003 Parameter: DATA_BITS, 8, data width per channel.
REQ-004 Parameter: LATENCY, 2, rising edges from request acceptance to ready assertion; legal range 1..15.
REQ-005 Ports: one clock and one reset; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-low reset.
REQ-008 mem_read_valid  input  CHANNELS  per-channel read request, held until ready seen.
REQ-009 mem_read_address  input  CHANNELS*ADDR_BITS  packed read addresses; channel i at bits [i*ADDR_BITS +: ADDR_BITS].
REQ-010 mem_read_ready  output  CHANNELS  per-channel read completion pulse.
REQ-011 mem_read_data  output  CHANNELS*DATA_BITS  packed read data, valid while ready high.
REQ-012 mem_write_valid  input  CHANNELS  per-channel write request, held until ready seen.
REQ-013 mem_write_address  input  CHANNELS*ADDR_BITS  packed write addresses.
REQ-014 mem_write_data  input  CHANNELS*DATA_BITS  packed write data.
REQ-015 mem_write_ready  output  CHANNELS  per-channel write completion pulse.

Function
REQ-016 Each channel SHALL run an independent FSM: IDLE, BUSY, RESPOND, RELEASE.
REQ-017 IDLE: at a rising edge with read_valid[i]=1, the channel SHALL latch the address, load the latency counter, and enter BUSY as a read; otherwise, with write_valid[i]=1, it SHALL latch address and data and enter BUSY as a write.
REQ-018 If read_valid[i] and write_valid[i] are both high in IDLE, the read SHALL be served first; the write is served on a later acceptance.
REQ-019 BUSY: the counter SHALL decrement each edge; ready[i] SHALL be high in the cycle following the LATENCY-th edge after acceptance, then the channel enters RESPOND.
REQ-020 RESPOND lasts exactly one cycle; the matching ready bit is high only here; then the channel enters RELEASE.
REQ-021 Read data SHALL be sampled from storage at the edge entering RESPOND and held in mem_read_data until the next read completion on that channel.
REQ-022 A write SHALL commit to storage at the edge entering RESPOND.
REQ-023 RELEASE: the channel SHALL return to IDLE at the first edge where the served valid bit is low; a new request is never accepted in that same edge.
REQ-024 Same-edge commits from several channels to one address: the lowest channel index wins.
REQ-025 Same-edge read sample and write commit to one address: the read returns the pre-write value.
REQ-026 Valid dropping early (BUSY) SHALL NOT abort the transaction; ready still pulses once.
REQ-027 Address and data inputs SHALL be ignored outside IDLE acceptance.

Reset
REQ-028 While reset=0, all FSMs SHALL be IDLE, counters 0, mem_read_ready=0, mem_write_ready=0, mem_read_data=0, and all storage bytes 0.
REQ-029 Reset asserted mid-transaction SHALL abandon it without a ready pulse or storage commit; after deassertion the first edge may accept a new request.

Configuration
REQ-030 Macro MEM_RESPONDER_WRITE_GUARD_EN: when defined, writes to addresses >= 8'hF0 SHALL be acknowledged normally but not committed, and an extra output write_violation (1 bit, sticky until reset) SHALL rise the cycle after such a commit edge.
REQ-031 Without MEM_RESPONDER_WRITE_GUARD_EN, all addresses are writable and write_violation does not exist.

Verification
REQ-032 Write ch0 addr 8'h10 data 8'hA5, LATENCY=2 -> write_ready[0] high exactly one cycle, 2 edges after acceptance; later read ch1 addr 8'h10 -> read_data ch1 = 8'hA5.
REQ-033 Reads on all 4 channels, same cycle, addrs 8'h00..8'h03 preloaded with 8'h11..8'h44 -> all four ready pulses in the same cycle with matching data.
REQ-034 Writes ch1 8'h20<-8'h01 and ch3 8'h20<-8'h02 same edge -> subsequent read of 8'h20 returns 8'h01.
REQ-035 Valid held high 3 cycles after ready pulse -> no second ready; drop valid -> IDLE next edge, next request accepted.
REQ-036 Reset driven low during BUSY of write 8'h30<-8'hFF -> no ready pulse; read 8'h30 after reset returns 8'h00.
REQ-037 With MEM_RESPONDER_WRITE_GUARD_EN, write 8'hF4<-8'h77 -> write_ready pulses, write_violation=1, read 8'hF4 returns 8'h00.
